// File: rtl/vco_sweep_ctrl.sv
// VCO control-word sweep sequencer: ramps an 8-bit word from start to stop with a per-word dwell.
// Define VCO_SWEEP_BIDIR_EN to add a return ramp from stop back to start before completion.
module vco_sweep_ctrl #(
    parameter int unsigned DWELL_W   = 16,
    parameter logic [7:0]  IDLE_WORD = 8'h00
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [7:0]         i_start_word,
    input  logic [7:0]         i_stop_word,
    input  logic [7:0]         i_step,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [7:0]         o_vco_data,
    output logic               o_word_stb,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [7:0]         word_q, word_d;
    logic               stb_q, stb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         target_q, target_d;
    logic [7:0]         step_q, step_d;
    logic               up_q, up_d;
`ifdef VCO_SWEEP_BIDIR_EN
    logic [7:0]         start_q, start_d;
    logic               phase_q, phase_d;
`endif

    // One step toward target in 9 bits; overshoot or wrap past 0/255 clamps onto target.
    function automatic logic [7:0] step_toward(
        input logic [7:0] word,
        input logic [7:0] target,
        input logic [7:0] step,
        input logic       up
    );
        logic [8:0] sum;
        logic [7:0] result;
        if (up) begin
            sum    = {1'b0, word} + {1'b0, step};
            result = (sum > {1'b0, target}) ? target : sum[7:0];
        end else begin
            sum    = {1'b0, word} - {1'b0, step};
            result = (sum[8] || (sum < {1'b0, target})) ? target : sum[7:0];
        end
        return result;
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d  = state_q;
        word_d   = word_q;
        stb_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        target_d = target_q;
        step_d   = step_q;
        up_d     = up_q;
`ifdef VCO_SWEEP_BIDIR_EN
        start_d  = start_q;
        phase_d  = phase_q;
`endif

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (i_start) begin
                    state_d  = S_SWEEP;
                    word_d   = i_start_word;
                    stb_d    = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = i_dwell;
                    dwell_d  = i_dwell;
                    target_d = i_stop_word;
                    step_d   = (i_step == 8'd0) ? 8'd1 : i_step;
                    up_d     = (i_stop_word >= i_start_word);
`ifdef VCO_SWEEP_BIDIR_EN
                    start_d  = i_start_word;
                    phase_d  = 1'b0;
`endif
                end
            end

            S_SWEEP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (word_q != target_q) begin
                    word_d = step_toward(word_q, target_q, step_q, up_q);
                    stb_d  = 1'b1;
                    cnt_d  = dwell_q;
`ifdef VCO_SWEEP_BIDIR_EN
                end else if (!phase_q && (start_q != target_q)) begin
                    // Turn around at stop; the stop word itself is not repeated.
                    phase_d  = 1'b1;
                    target_d = start_q;
                    up_d     = !up_q;
                    word_d   = step_toward(word_q, start_q, step_q, !up_q);
                    stb_d    = 1'b1;
                    cnt_d    = dwell_q;
`endif
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything, including a simultaneous start in IDLE.
        if (i_abort) begin
            state_d = S_IDLE;
            word_d  = IDLE_WORD;
            stb_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            word_q   <= IDLE_WORD;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            target_q <= 8'h00;
            step_q   <= 8'h01;
            up_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            stb_q    <= stb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            target_q <= target_d;
            step_q   <= step_d;
            up_q     <= up_d;
        end
    end

`ifdef VCO_SWEEP_BIDIR_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            start_q <= 8'h00;
            phase_q <= 1'b0;
        end else begin
            start_q <= start_d;
            phase_q <= phase_d;
        end
    end
`endif

    assign o_vco_data = word_q;
    assign o_word_stb = stb_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_vco_sweep_ctrl.sv
// Bench for vco_sweep_ctrl: list-based sweep model compared every cycle, plus literal sweep checks.
// Literal expectations follow VCO_SWEEP_BIDIR_EN when it is defined.
module tb_vco_sweep_ctrl;

    localparam int         DW     = 16;
    localparam logic [7:0] IDLE_W = 8'h00;

    logic          i_clk        = 1'b0;
    logic          i_reset_n    = 1'b0;
    logic          i_start      = 1'b0;
    logic          i_abort      = 1'b0;
    logic [7:0]    i_start_word = 8'h00;
    logic [7:0]    i_stop_word  = 8'h00;
    logic [7:0]    i_step       = 8'h00;
    logic [DW-1:0] i_dwell      = '0;
    logic [7:0]    o_vco_data;
    logic          o_word_stb;
    logic          o_busy;
    logic          o_done;

    vco_sweep_ctrl #(.DWELL_W(DW), .IDLE_WORD(IDLE_W)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_start_word (i_start_word),
        .i_stop_word  (i_stop_word),
        .i_step       (i_step),
        .i_dwell      (i_dwell),
        .o_vco_data   (o_vco_data),
        .o_word_stb   (o_word_stb),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: expected per-cycle output trace ----------------
    typedef struct packed {
        logic [7:0] vco;
        logic       stb;
        logic       busy;
        logic       done;
    } obs_t;

    localparam obs_t IDLE_OBS = '{vco: IDLE_W, stb: 1'b0, busy: 1'b0, done: 1'b0};

    obs_t exp_cur = IDLE_OBS;
    obs_t exp_q[$];

    function automatic int toward(input int w, input int target, input int step);
        if (w < target) return (w + step > target) ? target : w + step;
        return (w - step < target) ? target : w - step;
    endfunction

    function automatic void plan_sweep(input int s, input int e, input int st, input int d);
        int words[$];
        int w;
        int step;
        step = (st == 0) ? 1 : st;
        w = s;
        words.push_back(w);
        while (w != e) begin
            w = toward(w, e, step);
            words.push_back(w);
        end
`ifdef VCO_SWEEP_BIDIR_EN
        while (w != s) begin
            w = toward(w, s, step);
            words.push_back(w);
        end
`endif
        exp_q.delete();
        foreach (words[i])
            for (int k = 0; k <= d; k++)
                exp_q.push_back('{vco: 8'(words[i]), stb: (k == 0), busy: 1'b1, done: 1'b0});
        exp_q.push_back('{vco: 8'(w), stb: 1'b0, busy: 1'b1, done: 1'b1});
    endfunction

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            exp_q.delete();
            exp_cur = IDLE_OBS;
        end else if (i_abort) begin
            exp_q.delete();
            exp_cur = IDLE_OBS;
        end else if (exp_q.size() != 0) begin
            exp_cur = exp_q.pop_front();
        end else if (!exp_cur.busy && i_start) begin
            plan_sweep(int'(i_start_word), int'(i_stop_word), int'(i_step), int'(i_dwell));
            exp_cur = exp_q.pop_front();
        end else begin
            exp_cur = '{vco: exp_cur.vco, stb: 1'b0, busy: 1'b0, done: 1'b0};
        end
    end

    always @(negedge i_clk)
        check("cycle", 64'({o_vco_data, o_word_stb, o_busy, o_done}), 64'(exp_cur));

    // ---------------- directed sweep capture ----------------
    logic [7:0] obs_words[$];
    int         obs_stb_cyc[$];
    int         obs_done_cyc;

    function automatic logic [63:0] pack_words();
        logic [63:0] r = '0;
        foreach (obs_words[i]) r = {r[55:0], obs_words[i]};
        return r;
    endfunction

    function automatic logic [63:0] pack_cycles();
        logic [63:0] r = '0;
        foreach (obs_stb_cyc[i]) r = {r[55:0], 8'(obs_stb_cyc[i])};
        return r;
    endfunction

    // Cycle 1 is the first cycle after the edge that samples i_start.
    task automatic run_sweep(input logic [7:0] s, input logic [7:0] e, input logic [7:0] st,
                             input logic [DW-1:0] d, input bit scramble);
        @(negedge i_clk);
        i_start_word = s;
        i_stop_word  = e;
        i_step       = st;
        i_dwell      = d;
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        obs_words.delete();
        obs_stb_cyc.delete();
        obs_done_cyc = -1;
        for (int c = 1; c <= 600; c++) begin
            if (o_word_stb) begin
                obs_words.push_back(o_vco_data);
                obs_stb_cyc.push_back(c);
            end
            if (o_done) begin
                obs_done_cyc = c;
                break;
            end
            if (scramble) begin
                i_start_word = 8'($urandom);
                i_stop_word  = 8'($urandom);
                i_step       = 8'($urandom);
                i_dwell      = DW'($urandom);
                i_start      = 1'($urandom);
            end
            @(negedge i_clk);
        end
        i_start = 1'b0;
    endtask

    task automatic sweep_checks(input string name, input int nw, input logic [63:0] words,
                                input int done_cyc);
        check({name, "_nwords"}, 64'(obs_words.size()), 64'(nw));
        check({name, "_words"}, pack_words(), words);
        check({name, "_done_cyc"}, 64'(obs_done_cyc), 64'(done_cyc));
    endtask

`ifdef VCO_SWEEP_BIDIR_EN
    localparam int          A_NW = 7;
    localparam logic [63:0] A_W  = 64'({8'd10, 8'd20, 8'd30, 8'd40, 8'd30, 8'd20, 8'd10});
    localparam logic [63:0] A_C  = 64'({8'd1, 8'd4, 8'd7, 8'd10, 8'd13, 8'd16, 8'd19});
    localparam int          A_DC = 22;
    localparam logic [7:0]  A_P  = 8'd10;
    localparam int          B_NW = 7;
    localparam logic [63:0] B_W  = 64'({8'd200, 8'd196, 8'd192, 8'd190, 8'd194, 8'd198, 8'd200});
    localparam int          B_DC = 8;
    localparam logic [7:0]  B_P  = 8'd200;
    localparam int          C_NW = 3;
    localparam logic [63:0] C_W  = 64'({8'd250, 8'd255, 8'd250});
    localparam int          C_DC = 7;
    localparam int          D_NW = 5;
    localparam logic [63:0] D_W  = 64'({8'd5, 8'd6, 8'd7, 8'd6, 8'd5});
    localparam int          D_DC = 6;
    localparam int          E_NW = 5;
    localparam logic [63:0] E_W  = 64'({8'd10, 8'd20, 8'd30, 8'd20, 8'd10});
    localparam int          E_DC = 6;
    localparam logic [7:0]  E_P  = 8'd10;
`else
    localparam int          A_NW = 4;
    localparam logic [63:0] A_W  = 64'({8'd10, 8'd20, 8'd30, 8'd40});
    localparam logic [63:0] A_C  = 64'({8'd1, 8'd4, 8'd7, 8'd10});
    localparam int          A_DC = 13;
    localparam logic [7:0]  A_P  = 8'd40;
    localparam int          B_NW = 4;
    localparam logic [63:0] B_W  = 64'({8'd200, 8'd196, 8'd192, 8'd190});
    localparam int          B_DC = 5;
    localparam logic [7:0]  B_P  = 8'd190;
    localparam int          C_NW = 2;
    localparam logic [63:0] C_W  = 64'({8'd250, 8'd255});
    localparam int          C_DC = 5;
    localparam int          D_NW = 3;
    localparam logic [63:0] D_W  = 64'({8'd5, 8'd6, 8'd7});
    localparam int          D_DC = 4;
    localparam int          E_NW = 3;
    localparam logic [63:0] E_W  = 64'({8'd10, 8'd20, 8'd30});
    localparam int          E_DC = 4;
    localparam logic [7:0]  E_P  = 8'd30;
`endif

    initial begin
        bit found;
        int n_done;

        repeat (3) @(negedge i_clk);
        check("reset_state", 64'({o_vco_data, o_word_stb, o_busy, o_done}), 64'({IDLE_W, 3'b000}));
        i_reset_n = 1'b1;

        // Basic ramp, with configuration and start toggled during the sweep.
        run_sweep(8'd10, 8'd40, 8'd10, 16'd2, 1'b1);
        sweep_checks("ramp_up", A_NW, A_W, A_DC);
        check("ramp_up_stb_cyc", pack_cycles(), A_C);
        @(negedge i_clk);
        check("ramp_up_park", 64'({o_vco_data, o_busy}), 64'({A_P, 1'b0}));

        // Downward ramp with final clamp; park must persist.
        run_sweep(8'd200, 8'd190, 8'd4, 16'd0, 1'b0);
        sweep_checks("ramp_down", B_NW, B_W, B_DC);
        repeat (5) @(negedge i_clk);
        check("ramp_down_park", 64'({o_vco_data, o_busy}), 64'({B_P, 1'b0}));

        run_sweep(8'd250, 8'd255, 8'd10, 16'd1, 1'b0);
        sweep_checks("no_wrap", C_NW, C_W, C_DC);
        run_sweep(8'd5, 8'd7, 8'd0, 16'd0, 1'b0);
        sweep_checks("step_zero", D_NW, D_W, D_DC);
        run_sweep(8'd77, 8'd77, 8'd3, 16'd1, 1'b0);
        sweep_checks("single_word", 1, 64'd77, 3);
        run_sweep(8'd10, 8'd30, 8'd10, 16'd0, 1'b0);
        sweep_checks("short_ramp", E_NW, E_W, E_DC);
        @(negedge i_clk);
        check("short_ramp_park", 64'(o_vco_data), 64'(E_P));

        // Start and abort together in IDLE: abort wins, park cleared.
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        check("start_abort", 64'({o_vco_data, o_word_stb, o_busy, o_done}), 64'({IDLE_W, 3'b000}));
        repeat (3) @(negedge i_clk);
        check("start_abort_idle", 64'(o_busy), 64'd0);

        // Abort while word 30 is driven.
        i_start_word = 8'd10;
        i_stop_word  = 8'd40;
        i_step       = 8'd10;
        i_dwell      = 16'd2;
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (o_word_stb && (o_vco_data == 8'd30)) begin
                found = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        check("abort_reach_30", 64'(found), 64'd1);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("abort_out", 64'({o_vco_data, o_word_stb, o_busy, o_done}), 64'({IDLE_W, 3'b000}));
        n_done = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);

        // Asynchronous reset between edges, mid-sweep.
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        #2 i_reset_n = 1'b0;
        #1 check("async_reset", 64'({o_vco_data, o_word_stb, o_busy, o_done}), 64'({IDLE_W, 3'b000}));
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        run_sweep(8'd200, 8'd190, 8'd4, 16'd0, 1'b0);
        sweep_checks("after_reset", B_NW, B_W, B_DC);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge i_clk);
            i_start      = ($urandom_range(0, 3) == 0);
            i_abort      = ($urandom_range(0, 80) == 0);
            i_start_word = 8'($urandom);
            i_stop_word  = 8'($urandom);
            i_step       = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            i_dwell      = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 700) == 0) begin
                #2 i_reset_n = 1'b0;
                #4 i_reset_n = 1'b1;
            end
        end
        @(negedge i_clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        repeat (2) @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
